// File: rtl/phase_gen.sv
// -----------------------------------------------------------------------------
// phase_gen -- NCO phase front end
//
// Produces the (ce, phase, aux) sample stream that feeds sintable. A phase
// accumulator advances by a programmable step on every sample strobe. An
// optional linear frequency sweep (chirp) ramps the step up to a saturating
// stop value. Configuration words arrive over a valid/ready handshake and are
// applied without a phase jump when the block is already running.
//
// Configuration macro:
//   PHASE_DITHER_EN  when defined, a 16-bit LFSR adds DW bits of dither below
//                    the truncation point of the output phase. When undefined
//                    the phase is a pure truncation and no LFSR exists.
//
// Parameters:
//   AW  accumulator / step width
//   PW  output phase width (must match sintable PW)
//   DW  dither width, DW <= AW-PW (only used with PHASE_DITHER_EN)
//
// Ports:
//   i_clk         clock
//   i_reset_n     synchronous, active-low reset
//   i_ce          sample strobe, one phase sample per asserted cycle
//   i_cfg_valid   configuration word valid
//   o_cfg_ready   block can accept a configuration word
//   i_cfg_mode    0 STOP, 1 RUN, 2 SWEEP, 3 STOP (reserved)
//   i_cfg_step    start step (frequency word)
//   i_cfg_delta   sweep step increment per sample
//   i_cfg_stop    sweep final step
//   i_cfg_offset  phase offset added after truncation
//   o_ce          sample valid (to sintable i_ce)
//   o_phase       phase sample (to sintable i_phase)
//   o_aux         accumulator wrap flag, aligned with o_ce (to sintable i_aux)
//   o_busy        high whenever the state machine is not IDLE
//
// Handshake: a word transfers on a cycle where i_cfg_valid and o_cfg_ready are
// both high at the rising clock edge. o_cfg_ready is low while a transferred
// word is waiting to be applied; i_cfg_* must stay stable while i_cfg_valid is
// high and o_cfg_ready is low.
// -----------------------------------------------------------------------------
module phase_gen #(
    parameter int AW = 32,
    parameter int PW = 17,
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic          i_cfg_valid,
    output logic          o_cfg_ready,
    input  logic [1:0]    i_cfg_mode,
    input  logic [AW-1:0] i_cfg_step,
    input  logic [AW-1:0] i_cfg_delta,
    input  logic [AW-1:0] i_cfg_stop,
    input  logic [PW-1:0] i_cfg_offset,
    output logic          o_ce,
    output logic [PW-1:0] o_phase,
    output logic          o_aux,
    output logic          o_busy
);

    // Elaboration-time sanity check on the dither width.
    if (DW > AW - PW) begin : g_bad_dw
        $error("phase_gen: DW must not exceed AW-PW");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    localparam logic [1:0] MODE_RUN   = 2'd1;
    localparam logic [1:0] MODE_SWEEP = 2'd2;

    // ------------------------------------------------------------------
    // Architectural state
    // ------------------------------------------------------------------
    state_t        state;
    logic [AW-1:0] acc;
    logic [AW-1:0] step;
    logic [AW-1:0] delta;
    logic [AW-1:0] stop_step;
    logic [PW-1:0] offset;

    // Pending configuration word (one-deep holding register)
    logic          pending;
    logic [1:0]    pend_mode;
    logic [AW-1:0] pend_step;
    logic [AW-1:0] pend_delta;
    logic [AW-1:0] pend_stop;
    logic [PW-1:0] pend_offset;

`ifdef PHASE_DITHER_EN
    logic [15:0]   lfsr;
    logic          lfsr_fb;
    logic [AW-1:0] dith_sum;
`endif

    // ------------------------------------------------------------------
    // Combinational next-state view
    //
    // The eff_* signals describe the configuration as seen by this cycle's
    // sample: if a pending word is applied on this edge, the sample already
    // uses the new step/offset.
    // ------------------------------------------------------------------
    logic          accept;
    logic          apply;
    state_t        eff_state;
    logic [AW-1:0] eff_acc;
    logic [AW-1:0] eff_step;
    logic [AW-1:0] eff_delta;
    logic [AW-1:0] eff_stop;
    logic [PW-1:0] eff_offset;

    logic          sample;
    logic [AW:0]   acc_sum;
    logic [AW-1:0] acc_new;
    logic          acc_carry;
    logic [AW:0]   step_sum;
    logic          sweep_done;
    logic [AW-1:0] swept_step;
    logic [PW-1:0] phase_trunc;
    logic [PW-1:0] phase_out;

    assign o_cfg_ready = !pending;
    assign o_busy      = (state != ST_IDLE);
    assign accept      = i_cfg_valid && !pending;

    // In IDLE the word applies on the cycle after acceptance regardless of
    // i_ce; when running it waits for the next strobe. Because pending is a
    // register, an i_ce in the acceptance cycle itself never sees the word.
    assign apply = pending && ((state == ST_IDLE) || i_ce);

    always_comb begin
        eff_state  = state;
        eff_acc    = acc;
        eff_step   = step;
        eff_delta  = delta;
        eff_stop   = stop_step;
        eff_offset = offset;

        if (apply) begin
            eff_step   = pend_step;
            eff_delta  = pend_delta;
            eff_stop   = pend_stop;
            eff_offset = pend_offset;

            if (pend_mode == MODE_RUN || pend_mode == MODE_SWEEP) begin
                // Starting from IDLE restarts the phase; a running block keeps
                // its accumulator so the change is phase-continuous.
                if (state == ST_IDLE) begin
                    eff_acc = '0;
                end
                if (pend_mode == MODE_RUN) begin
                    eff_state = ST_RUN;
                end else if (pend_step >= pend_stop) begin
                    // Sweep that is already at or past its end: clamp and run.
                    eff_step  = pend_stop;
                    eff_state = ST_RUN;
                end else begin
                    eff_state = ST_SWEEP;
                end
            end else begin
                // STOP and the reserved code both return to IDLE.
                eff_state = ST_IDLE;
                eff_acc   = '0;
            end
        end
    end

    // A sample is produced only by a strobe that arrives while running and
    // that does not itself stop the block. IDLE ignores i_ce, including the
    // cycle in which a RUN/SWEEP word is applied from IDLE.
    assign sample = i_ce && (state != ST_IDLE) && (eff_state != ST_IDLE);

    // Accumulator with explicit carry; the carry is the wrap flag.
    assign acc_sum   = {1'b0, eff_acc} + {1'b0, eff_step};
    assign acc_new   = acc_sum[AW-1:0];
    assign acc_carry = acc_sum[AW];

    // Sweep update computed one bit wider so it can never wrap past stop.
    assign step_sum   = {1'b0, eff_step} + {1'b0, eff_delta};
    assign sweep_done = (step_sum >= {1'b0, eff_stop});
    assign swept_step = sweep_done ? eff_stop : step_sum[AW-1:0];

`ifdef PHASE_DITHER_EN
    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB.
    assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    // Dither only shapes the truncation; acc and the carry stay exact.
    assign dith_sum    = acc_new + {{(AW-DW){1'b0}}, lfsr[DW-1:0]};
    assign phase_trunc = dith_sum[AW-1 -: PW];
`else
    assign phase_trunc = acc_new[AW-1 -: PW];
`endif

    // Offset is added after truncation and wraps modulo 2^PW.
    assign phase_out = phase_trunc + eff_offset;

    // ------------------------------------------------------------------
    // Sequential logic: state machine, configuration, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            step        <= '0;
            delta       <= '0;
            stop_step   <= '0;
            offset      <= '0;
            pending     <= 1'b0;
            pend_mode   <= 2'd0;
            pend_step   <= '0;
            pend_delta  <= '0;
            pend_stop   <= '0;
            pend_offset <= '0;
            o_ce        <= 1'b0;
            o_phase     <= '0;
            o_aux       <= 1'b0;
        end else begin
            // Holding register. accept requires !pending and apply requires
            // pending, so the two never happen in the same cycle.
            if (accept) begin
                pending     <= 1'b1;
                pend_mode   <= i_cfg_mode;
                pend_step   <= i_cfg_step;
                pend_delta  <= i_cfg_delta;
                pend_stop   <= i_cfg_stop;
                pend_offset <= i_cfg_offset;
            end else if (apply) begin
                pending <= 1'b0;
            end

            delta     <= eff_delta;
            stop_step <= eff_stop;
            offset    <= eff_offset;

            if (sample) begin
                acc <= acc_new;
                if (eff_state == ST_SWEEP) begin
                    step <= swept_step;
                    // Reaching the stop frequency ends the chirp.
                    state <= sweep_done ? ST_RUN : ST_SWEEP;
                end else begin
                    step  <= eff_step;
                    state <= eff_state;
                end
            end else begin
                acc   <= eff_acc;
                step  <= eff_step;
                state <= eff_state;
            end

            // Registered outputs, one cycle after the strobe. o_phase holds
            // between samples; o_aux is only meaningful alongside o_ce.
            o_ce <= sample;
            if (sample) begin
                o_phase <= phase_out;
                o_aux   <= acc_carry;
            end else begin
                o_aux   <= 1'b0;
            end
        end
    end

`ifdef PHASE_DITHER_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            lfsr <= 16'hACE1;
        end else if (sample) begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end
`endif

endmodule

// File: tb/tb_phase_gen.sv
// -----------------------------------------------------------------------------
// tb_phase_gen -- directed, scoreboard-checked bench for phase_gen
//
// Stimulus tasks push the hand-computed {aux, phase} for every strobe into
// exp_q; an independent monitor on the falling edge pops and compares each
// time the DUT raises o_ce. Static status outputs are checked directly.
// -----------------------------------------------------------------------------
module tb_phase_gen;

    localparam int AW = 32;
    localparam int PW = 17;

    // ------------------------------------------------------------------
    // Clock / reset and DUT signals
    // ------------------------------------------------------------------
    logic          i_clk = 1'b0;
    logic          i_reset_n;
    logic          i_ce;
    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [1:0]    i_cfg_mode;
    logic [AW-1:0] i_cfg_step;
    logic [AW-1:0] i_cfg_delta;
    logic [AW-1:0] i_cfg_stop;
    logic [PW-1:0] i_cfg_offset;
    logic          o_ce;
    logic [PW-1:0] o_phase;
    logic          o_aux;
    logic          o_busy;

    always #5 i_clk = ~i_clk;

    phase_gen #(.AW(AW), .PW(PW), .DW(8)) dut (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_ce         (i_ce),
        .i_cfg_valid  (i_cfg_valid),
        .o_cfg_ready  (o_cfg_ready),
        .i_cfg_mode   (i_cfg_mode),
        .i_cfg_step   (i_cfg_step),
        .i_cfg_delta  (i_cfg_delta),
        .i_cfg_stop   (i_cfg_stop),
        .i_cfg_offset (i_cfg_offset),
        .o_ce         (o_ce),
        .o_phase      (o_phase),
        .o_aux        (o_aux),
        .o_busy       (o_busy)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [PW:0] exp_q[$];   // {aux, phase}
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every o_ce must match the oldest expected sample.
    always @(negedge i_clk) begin
        if (o_ce === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sample_unexpected: got phase=%05h aux=%b expected no sample",
                         o_phase, o_aux);
            end else begin
                logic [PW:0] exp;
                exp = exp_q.pop_front();
                if ({o_aux, o_phase} !== exp) begin
                    n_fail++;
                    $display("FAIL sample: got phase=%05h aux=%b expected phase=%05h aux=%b",
                             o_phase, o_aux, exp[PW-1:0], exp[PW]);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One strobe; leaves i_ce high so consecutive calls run at full rate.
    task automatic ce_pulse(input logic [PW-1:0] phase, input logic aux);
        exp_q.push_back({aux, phase});
        i_ce = 1'b1;
        tick();
    endtask

    task automatic send_cfg(input logic [1:0] mode, input logic [AW-1:0] step,
                            input logic [AW-1:0] delta, input logic [AW-1:0] stop,
                            input logic [PW-1:0] offset);
        bit done;
        done         = 1'b0;
        i_cfg_valid  = 1'b1;
        i_cfg_mode   = mode;
        i_cfg_step   = step;
        i_cfg_delta  = delta;
        i_cfg_stop   = stop;
        i_cfg_offset = offset;
        for (int i = 0; i < 16 && !done; i++) begin
            if (o_cfg_ready === 1'b1) done = 1'b1;
            tick();
        end
        i_cfg_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg_timeout: got o_cfg_ready=0 for 16 cycles expected 1");
        end
    endtask

    task automatic do_reset(input int cycles);
        i_reset_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        i_reset_n = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_o_ce"},    32'(o_ce),        32'd0);
        check({tag, "_o_phase"}, 32'(o_phase),     32'd0);
        check({tag, "_o_aux"},   32'(o_aux),       32'd0);
        check({tag, "_ready"},   32'(o_cfg_ready), 32'd1);
        check({tag, "_busy"},    32'(o_busy),      32'd0);
    endtask

    // Watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    initial begin
        i_reset_n    = 1'b0;
        i_ce         = 1'b0;
        i_cfg_valid  = 1'b0;
        i_cfg_mode   = 2'd0;
        i_cfg_step   = '0;
        i_cfg_delta  = '0;
        i_cfg_stop   = '0;
        i_cfg_offset = '0;

        // 1. Reset for 3 cycles, then a strobe in IDLE must be ignored.
        do_reset(3);
        i_ce = 1'b1;
        tick();
        i_ce = 1'b0;
        tick();
        check_reset_outputs("idle");

        // 2. RUN, step = 1/4 turn, offset 0, strobe every cycle for two turns.
        send_cfg(2'd1, 32'h4000_0000, '0, '0, '0);
        tick();   // applied from IDLE on this edge
        check("run_busy", 32'(o_busy), 32'd1);
        check("run_ready", 32'(o_cfg_ready), 32'd1);
        for (int r = 0; r < 2; r++) begin
            ce_pulse(17'h08000, 1'b0);
            ce_pulse(17'h10000, 1'b0);
            ce_pulse(17'h18000, 1'b0);
            ce_pulse(17'h00000, 1'b1);
        end
        i_ce = 1'b0;
        tick();

        // 3. Same step, offset 17'h18000; applied at first strobe, acc is 0.
        send_cfg(2'd1, 32'h4000_0000, '0, '0, 17'h18000);
        check("offset_ready_low", 32'(o_cfg_ready), 32'd0);
        ce_pulse(17'h00000, 1'b0);
        ce_pulse(17'h08000, 1'b0);
        ce_pulse(17'h10000, 1'b0);
        ce_pulse(17'h18000, 1'b1);
        i_ce = 1'b0;
        tick();

        // 4. Handshake: word held pending while i_ce is low.
        send_cfg(2'd1, 32'h8000_0000, '0, '0, '0);
        for (int i = 0; i < 3; i++) begin
            check("hs_ready_low", 32'(o_cfg_ready), 32'd0);
            tick();
        end
        check("hs_busy", 32'(o_busy), 32'd1);
        ce_pulse(17'h10000, 1'b0);   // new step on the applying strobe
        i_ce = 1'b0;
        check("hs_ready_back", 32'(o_cfg_ready), 32'd1);
        ce_pulse(17'h00000, 1'b1);   // continuous: 0x8000_0000 + 0x8000_0000 wraps
        i_ce = 1'b0;
        tick();

        // 5. Sweep from a fresh reset.
        do_reset(1);
        tick();
        check_reset_outputs("pre_sweep");
        send_cfg(2'd2, 32'h0100_0000, 32'h0100_0000, 32'h0400_0000, '0);
        tick();
        check("sweep_busy", 32'(o_busy), 32'd1);
        ce_pulse(17'h00200, 1'b0);
        ce_pulse(17'h00600, 1'b0);
        ce_pulse(17'h00C00, 1'b0);
        ce_pulse(17'h01400, 1'b0);
        ce_pulse(17'h01C00, 1'b0);
        ce_pulse(17'h02400, 1'b0);   // step held at stop
        i_ce = 1'b0;
        tick();
        check("sweep_run_busy", 32'(o_busy), 32'd1);

        // 6. Mid-sweep reset with i_ce high on the reset edge.
        do_reset(1);
        send_cfg(2'd2, 32'h0100_0000, 32'h0100_0000, 32'h0400_0000, '0);
        tick();
        ce_pulse(17'h00200, 1'b0);
        ce_pulse(17'h00600, 1'b0);
        i_reset_n = 1'b0;
        tick();   // reset edge, i_ce still high, no sample expected
        i_reset_n = 1'b1;
        check_reset_outputs("mid_reset");
        for (int i = 0; i < 3; i++) tick();   // i_ce stays high, still IDLE
        i_ce = 1'b0;
        check("post_reset_o_ce", 32'(o_ce), 32'd0);
        check("post_reset_busy", 32'(o_busy), 32'd0);
        send_cfg(2'd1, 32'h4000_0000, '0, '0, '0);
        tick();
        ce_pulse(17'h08000, 1'b0);   // acc restarted from 0
        i_ce = 1'b0;
        tick();
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
